// File: rtl/htg_ad9213_align_pkg.sv
// Shared types and default geometry for the AD9213 multi-core deskew block.
package htg_ad9213_align_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RUN   = 3'd3,
    ST_ERR   = 3'd4
  } align_state_t;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int unsigned skew_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

  localparam int unsigned DEF_SAMPLES    = 32;
  localparam int unsigned DEF_SAMPLE_W   = 12;
  localparam int unsigned DEF_FIFO_DEPTH = 16;
  localparam int unsigned WORD_W         = DEF_SAMPLES * DEF_SAMPLE_W;
  localparam int unsigned PTR_W          = ptr_width(DEF_FIFO_DEPTH);
  localparam int unsigned SKEW_W         = skew_width(DEF_FIFO_DEPTH);

endpackage

// File: rtl/htg_ad9213_align_fifo.sv
// Single-clock per-core FIFO with registered read data and wrap-bit pointers.
module htg_ad9213_align_fifo
  import htg_ad9213_align_pkg::*;
#(
  parameter int unsigned W     = WORD_W,
  parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         wr_en,
  input  logic         rd_en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned AW = PW - 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd = rd_en && !empty && !flush;
  // A simultaneous read frees the slot, so a write while full is accepted then.
  assign do_wr = wr_en && !flush && (!full || do_rd);

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      dout   <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PW'(1);
      if (do_rd) begin
        dout   <= mem[rd_ptr[AW-1:0]];
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

endmodule

// File: rtl/htg_ad9213_multi_align.sv
// Aligns per-core JESD sample words on their SYSREF markers so word k of every
// enabled core leaves in the same cycle.
module htg_ad9213_multi_align
  import htg_ad9213_align_pkg::*;
#(
  parameter int unsigned        N_CORES    = 4,
  parameter int unsigned        SAMPLES    = DEF_SAMPLES,
  parameter int unsigned        SAMPLE_W   = DEF_SAMPLE_W,
  parameter int unsigned        FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter logic [N_CORES-1:0] CORE_MASK  = 4'b0111
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  arm,
  input  logic [N_CORES*SAMPLES*SAMPLE_W-1:0]   din,
  input  logic [N_CORES-1:0]                    din_valid,
  input  logic [N_CORES-1:0]                    din_mark,
  output logic [N_CORES*SAMPLES*SAMPLE_W-1:0]   dout,
  output logic                                  dout_valid,
  output logic                                  aligned,
  output logic                                  err_timeout,
  output logic                                  err_ovf,
  output logic [N_CORES*$clog2(FIFO_DEPTH)-1:0] skew
);

  localparam int unsigned CW  = SAMPLES * SAMPLE_W;
  localparam int unsigned SW  = skew_width(FIFO_DEPTH);
  localparam logic [SW-1:0] TMO = SW'(FIFO_DEPTH - 2);

  align_state_t state_q, state_d;
  logic [SW-1:0]         cnt_q, cnt_d;
  logic [N_CORES-1:0]    seen_q, seen_d;
  logic [N_CORES*SW-1:0] skew_q, skew_d;
  logic                  tmo_d, ovf_d;

  logic [N_CORES-1:0] mark_now, wr_en, full, empty;
  logic               arm_take, live, capture, rd_en, ovf, all_seen;

  assign arm_take = arm && (state_q != ST_ARMED);
  assign live     = !arm_take && (state_q == ST_ARMED || state_q == ST_WAIT || state_q == ST_RUN);
  assign capture  = !arm_take && (state_q == ST_ARMED || state_q == ST_WAIT);
  assign mark_now = capture ? (din_valid & din_mark & CORE_MASK & ~seen_q) : '0;
  // Once a core has its marker every valid word is data, including later markers.
  assign wr_en    = live ? (din_valid & CORE_MASK & (seen_q | din_mark)) : '0;
  assign rd_en    = !arm_take && (state_q == ST_RUN) && (&(~empty | ~CORE_MASK));
  assign ovf      = !arm_take && (state_q == ST_WAIT || state_q == ST_RUN)
                    && |(wr_en & full & ~{N_CORES{rd_en}});
  assign all_seen = (CORE_MASK != '0) && (((seen_q | mark_now) & CORE_MASK) == CORE_MASK);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    seen_d  = seen_q;
    skew_d  = skew_q;
    tmo_d   = err_timeout;
    ovf_d   = err_ovf;
    if (arm_take) begin
      state_d = ST_ARMED;
      cnt_d   = '0;
      seen_d  = '0;
      skew_d  = '0;
      tmo_d   = 1'b0;
      ovf_d   = 1'b0;
    end else begin
      seen_d = seen_q | mark_now;
      for (int unsigned c = 0; c < N_CORES; c++) begin
        if (mark_now[c]) skew_d[c*SW +: SW] = cnt_q;
      end
      unique case (state_q)
        ST_ARMED: begin
          // cnt counts cycles since the first marker, so WAIT is entered at 1.
          if (|mark_now) begin
            if (all_seen) state_d = ST_RUN;
            else begin
              state_d = ST_WAIT;
              cnt_d   = SW'(1);
            end
          end
        end
        ST_WAIT: begin
          if (ovf) begin
            state_d = ST_ERR;
            ovf_d   = 1'b1;
          end else if (all_seen) begin
            state_d = ST_RUN;
          end else if (cnt_q == TMO) begin
            state_d = ST_ERR;
            tmo_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + SW'(1);
          end
        end
        ST_RUN: begin
          if (ovf) begin
            state_d = ST_ERR;
            ovf_d   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      seen_q      <= '0;
      skew_q      <= '0;
      err_timeout <= 1'b0;
      err_ovf     <= 1'b0;
      dout_valid  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      seen_q      <= seen_d;
      skew_q      <= skew_d;
      err_timeout <= tmo_d;
      err_ovf     <= ovf_d;
      dout_valid  <= rd_en;
    end
  end

  assign aligned = (state_q == ST_RUN);
  assign skew    = skew_q;

  for (genvar c = 0; c < N_CORES; c++) begin : g_core
    logic [CW-1:0] rd_word;

    htg_ad9213_align_fifo #(
      .W     (CW),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .flush   (arm_take),
      .wr_en   (wr_en[c]),
      .rd_en   (rd_en),
      .din     (din[c*CW +: CW]),
      .dout    (rd_word),
      .full    (full[c]),
      .empty   (empty[c])
    );

    assign dout[c*CW +: CW] = CORE_MASK[c] ? rd_word : '0;
  end

endmodule

// File: tb/tb_htg_ad9213_multi_align.sv
// Bench for htg_ad9213_multi_align: scenario table plus randomized marker delays,
// scored against per-core queues of post-marker words.
module tb_htg_ad9213_multi_align;

  localparam int unsigned N     = 4;
  localparam int unsigned SAMP  = 32;
  localparam int unsigned SMPW  = 12;
  localparam int unsigned WW    = SAMP * SMPW;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned SKW   = 4;
  localparam logic [3:0]  MASK  = 4'b0111;
  localparam int unsigned NEVER = 1000;

  logic              clk;
  logic              reset_n;
  logic              arm;
  logic [N*WW-1:0]   din;
  logic [N-1:0]      din_valid;
  logic [N-1:0]      din_mark;
  logic [N*WW-1:0]   dout;
  logic              dout_valid;
  logic              aligned;
  logic              err_timeout;
  logic              err_ovf;
  logic [N*SKW-1:0]  skew;

  htg_ad9213_multi_align #(
    .N_CORES    (N),
    .SAMPLES    (SAMP),
    .SAMPLE_W   (SMPW),
    .FIFO_DEPTH (DEPTH),
    .CORE_MASK  (MASK)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .arm         (arm),
    .din         (din),
    .din_valid   (din_valid),
    .din_mark    (din_mark),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .aligned     (aligned),
    .err_timeout (err_timeout),
    .err_ovf     (err_ovf),
    .skew        (skew)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk_w(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [WW-1:0] mkword(input int unsigned c, input int unsigned n);
    logic [WW-1:0] w;
    w = '0;
    for (int s = 0; s < SAMP; s++) w[s*SMPW +: SMPW] = SMPW'((c << 9) + n * 3 + s);
    return w;
  endfunction

  function automatic logic [WW-1:0] rndword();
    logic [WW-1:0] w;
    w = '0;
    for (int s = 0; s < SAMP; s++) w[s*SMPW +: SMPW] = SMPW'($urandom);
    return w;
  endfunction

  // Reference: each enabled core's output stream is its valid words from its first marker on.
  logic [WW-1:0] q [3][$];
  logic [WW-1:0] mon_e;
  int first_v, last_v, nvalid;

  always @(negedge clk) begin
    if (reset_n === 1'b1 && dout_valid === 1'b1) begin
      if (first_v < 0) first_v = cyc;
      last_v = cyc;
      nvalid++;
      for (int c = 0; c < 3; c++) begin
        if (q[c].size() > 0) mon_e = q[c].pop_front();
        else mon_e = '1;
        chk_w($sformatf("data_core%0d", c), dout[c*WW +: WW], mon_e);
      end
      chk_w("masked_slice", dout[3*WW +: WW], '0);
    end
  end

  typedef struct {
    int unsigned d0, d1, d2;
    int unsigned nw;
    int          stall_c;
    int unsigned st_at, st_len;
    int unsigned abort_at;
    bit          exp_tmo, exp_ovf;
    int unsigned sk0, sk1, sk2;
    int unsigned first;
    int unsigned gap;
  } vec_t;

  function automatic vec_t mkvec(input int unsigned d0, d1, d2, nw, input int stall_c,
                                 input int unsigned st_at, st_len, abort_at,
                                 input bit exp_tmo, exp_ovf,
                                 input int unsigned sk0, sk1, sk2, first, gap);
    vec_t v;
    v.d0 = d0; v.d1 = d1; v.d2 = d2; v.nw = nw;
    v.stall_c = stall_c; v.st_at = st_at; v.st_len = st_len; v.abort_at = abort_at;
    v.exp_tmo = exp_tmo; v.exp_ovf = exp_ovf;
    v.sk0 = sk0; v.sk1 = sk1; v.sk2 = sk2; v.first = first; v.gap = gap;
    return v;
  endfunction

  task automatic drive_noise3();
    din_valid[3]      = 1'($urandom_range(0, 1));
    din_mark[3]       = 1'($urandom_range(0, 1));
    din[3*WW +: WW]   = rndword();
  endtask

  task automatic apply(input vec_t v, input string tag);
    int unsigned d[3];
    int unsigned n[3];
    int unsigned mind, maxd, len;
    int t0;
    bit stalled;
    logic [WW-1:0] w;
    d[0] = v.d0; d[1] = v.d1; d[2] = v.d2;
    mind = NEVER; maxd = 0;
    for (int c = 0; c < 3; c++) begin
      n[c] = 0;
      if (d[c] < mind) mind = d[c];
      if (d[c] != NEVER && d[c] > maxd) maxd = d[c];
    end
    len = maxd + v.nw + v.st_len + 8;
    if (len < mind + 20) len = mind + 20;
    t0 = 0;

    @(negedge clk);
    arm = 1'b1; din_valid = '0; din_mark = '0;
    for (int c = 0; c < 3; c++) q[c].delete();
    first_v = -1; last_v = -1; nvalid = 0;

    for (int unsigned k = 0; k < len; k++) begin
      @(negedge clk);
      arm = 1'b0;
      if (k == 0) begin
        t0 = cyc;
        chk_i({tag, " armed_aligned"}, 32'(aligned), 0);
        chk_i({tag, " armed_err_timeout"}, 32'(err_timeout), 0);
        chk_i({tag, " armed_err_ovf"}, 32'(err_ovf), 0);
      end
      if (v.exp_tmo && cyc == t0 + int'(mind) + 14) chk_i({tag, " tmo_early"}, 32'(err_timeout), 0);
      if (v.exp_tmo && cyc == t0 + int'(mind) + 15) begin
        chk_i({tag, " tmo_set"}, 32'(err_timeout), 1);
        chk_i({tag, " tmo_no_valid"}, 32'(dout_valid), 0);
      end
      if (v.abort_at != 0 && k == v.abort_at) begin
        arm = 1'b1;
        din_valid = '1;
        din_mark  = '1;
        @(negedge clk);
        arm = 1'b0; din_valid = '0; din_mark = '0;
        chk_i({tag, " rearm_aligned"}, 32'(aligned), 0);
        chk_i({tag, " rearm_dout_valid"}, 32'(dout_valid), 0);
        chk_i({tag, " rearm_skew"}, 32'(skew), 0);
        chk_w({tag, " rearm_masked_slice"}, dout[3*WW +: WW], '0);
        return;
      end
      for (int c = 0; c < 3; c++) begin
        stalled = (c == v.stall_c) && k >= v.st_at && k < v.st_at + v.st_len;
        if (d[c] == NEVER || k < d[c]) begin
          din_valid[c] = 1'($urandom_range(0, 1));
          din_mark[c]  = din_valid[c] ? 1'b0 : 1'($urandom_range(0, 1));
          din[c*WW +: WW] = rndword();
        end else if (n[c] < v.nw && !stalled) begin
          w = mkword(c, n[c]);
          din_valid[c] = 1'b1;
          din_mark[c]  = (k == d[c]) || ($urandom_range(0, 7) == 0);
          din[c*WW +: WW] = w;
          q[c].push_back(w);
          n[c]++;
        end else begin
          din_valid[c] = 1'b0;
          din_mark[c]  = 1'($urandom_range(0, 1));
          din[c*WW +: WW] = rndword();
        end
      end
      drive_noise3();
    end

    @(negedge clk);
    din_valid = '0; din_mark = '0;
    if (v.exp_tmo || v.exp_ovf) begin
      chk_i({tag, " err_timeout"}, 32'(err_timeout), 32'(v.exp_tmo));
      chk_i({tag, " err_ovf"}, 32'(err_ovf), 32'(v.exp_ovf));
      chk_i({tag, " err_aligned"}, 32'(aligned), 0);
      chk_i({tag, " err_dout_valid"}, 32'(dout_valid), 0);
      if (v.exp_tmo) chk_i({tag, " tmo_words"}, nvalid, 0);
    end else begin
      chk_i({tag, " skew0"}, 32'(skew[0*SKW +: SKW]), int'(v.sk0));
      chk_i({tag, " skew1"}, 32'(skew[1*SKW +: SKW]), int'(v.sk1));
      chk_i({tag, " skew2"}, 32'(skew[2*SKW +: SKW]), int'(v.sk2));
      chk_i({tag, " skew3"}, 32'(skew[3*SKW +: SKW]), 0);
      chk_i({tag, " first_valid"}, first_v, t0 + int'(mind) + int'(v.first));
      chk_i({tag, " word_count"}, nvalid, int'(v.nw));
      chk_i({tag, " gap"}, (last_v - first_v + 1) - nvalid, int'(v.gap));
      chk_i({tag, " leftover"}, q[0].size() + q[1].size() + q[2].size(), 0);
      chk_i({tag, " aligned"}, 32'(aligned), 1);
      chk_i({tag, " err_flags"}, 32'({err_timeout, err_ovf}), 0);
    end
  endtask

  vec_t tbl[$];

  initial begin
    int unsigned rd0, rd1, rd2, mn, mx;
    first_v = -1; last_v = -1; nvalid = 0;

    tbl.push_back(mkvec(0, 0, 0, 20, -1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0));
    tbl.push_back(mkvec(0, 3, 5, 20, -1, 0, 0, 0, 0, 0, 0, 3, 5, 7, 0));
    tbl.push_back(mkvec(2, 0, 1, 16, -1, 0, 0, 0, 0, 0, 2, 0, 1, 4, 0));
    tbl.push_back(mkvec(0, 14, 7, 20, -1, 0, 0, 0, 0, 0, 0, 14, 7, 16, 0));
    tbl.push_back(mkvec(0, 0, NEVER, 20, -1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mkvec(4, 4, 0, 12, -1, 0, 0, 0, 0, 0, 4, 4, 0, 6, 0));
    tbl.push_back(mkvec(0, 0, 0, 20, 1, 6, 4, 0, 0, 0, 0, 0, 0, 2, 4));
    tbl.push_back(mkvec(1, 1, 1, 40, 1, 6, 20, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mkvec(0, 15, 3, 20, -1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mkvec(0, 2, 1, 40, -1, 0, 0, 12, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mkvec(3, 0, 2, 20, -1, 0, 0, 0, 0, 0, 3, 0, 2, 5, 0));
    for (int r = 0; r < 10; r++) begin
      rd0 = $urandom_range(0, 16);
      rd1 = $urandom_range(0, 16);
      rd2 = $urandom_range(0, 16);
      mn = rd0; mx = rd0;
      if (rd1 < mn) mn = rd1;
      if (rd2 < mn) mn = rd2;
      if (rd1 > mx) mx = rd1;
      if (rd2 > mx) mx = rd2;
      tbl.push_back(mkvec(rd0, rd1, rd2, $urandom_range(6, 30), -1, 0, 0, 0,
                          (mx - mn) > 14, 0, rd0 - mn, rd1 - mn, rd2 - mn, mx - mn + 2, 0));
    end

    reset_n = 1'b0; arm = 1'b0; din = '0; din_valid = '1; din_mark = '1;
    repeat (3) @(negedge clk);
    chk_w("reset_dout_lo", dout[0 +: WW], '0);
    chk_w("reset_dout_hi", dout[3*WW +: WW], '0);
    chk_i("reset_dout_valid", 32'(dout_valid), 0);
    chk_i("reset_aligned", 32'(aligned), 0);
    chk_i("reset_errs", 32'({err_timeout, err_ovf}), 0);
    chk_i("reset_skew", 32'(skew), 0);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      din_valid = 4'($urandom_range(0, 15));
      din_mark  = 4'($urandom_range(0, 15));
      @(negedge clk);
      chk_i("idle_dout_valid", 32'(dout_valid), 0);
      chk_i("idle_aligned", 32'(aligned), 0);
    end

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
